// File: rtl/compmc_pkg.sv
// Shared definitions for the compmc window comparator.
//   win_state_e : per-channel window state encoding (INSIDE/ABOVE/BELOW)
//   SAT_W       : working width of the saturating helpers (operands are
//                 zero- or sign-extended to SAT_W before the call)
//   sat_*       : saturating add/sub; signed variants clamp to the w-bit
//                 two's-complement range, unsigned variants to [0, 2^w-1]
package compmc_pkg;

   typedef enum logic [1:0] {
      ST_INSIDE = 2'd0,
      ST_ABOVE  = 2'd1,
      ST_BELOW  = 2'd2
   } win_state_e;

   localparam int unsigned SAT_W = 64;

   function automatic logic [SAT_W-1:0] sat_sub_u(input logic [SAT_W-1:0] a,
                                                  input logic [SAT_W-1:0] b);
      return (b > a) ? '0 : (a - b);
   endfunction

   function automatic logic [SAT_W-1:0] sat_add_u(input logic [SAT_W-1:0] a,
                                                  input logic [SAT_W-1:0] b,
                                                  input int unsigned      w);
      logic [SAT_W-1:0] s;
      logic [SAT_W-1:0] lim;
      lim = (SAT_W'(1) << w) - SAT_W'(1);
      s   = a + b;
      return (s > lim) ? lim : s;
   endfunction

   function automatic logic [SAT_W-1:0] sat_sub_s(input logic [SAT_W-1:0] a,
                                                  input logic [SAT_W-1:0] b,
                                                  input int unsigned      w);
      logic signed [SAT_W-1:0] d;
      logic signed [SAT_W-1:0] lim;
      lim = -(SAT_W'(1) << (w - 1));
      d   = $signed(a) - $signed(b);
      return (d < lim) ? lim : d;
   endfunction

   function automatic logic [SAT_W-1:0] sat_add_s(input logic [SAT_W-1:0] a,
                                                  input logic [SAT_W-1:0] b,
                                                  input int unsigned      w);
      logic signed [SAT_W-1:0] s;
      logic signed [SAT_W-1:0] lim;
      lim = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
      s   = $signed(a) + $signed(b);
      return (s > lim) ? lim : s;
   endfunction

endpackage

// File: rtl/compmc_win_chan.sv
// One channel of the window comparator: compare against the window, pick a
// target state, run the persistence filter and drive state/pulse outputs.
// Optional feature macro: STICKY_XING_EN (adds clr_i / sticky_o).
//   clk_i, rst_i      : clock, synchronous active-high reset
//   sample_i          : stage-1 holds a valid sample this cycle
//   a_i               : channel sample
//   hi_i, lo_i        : window thresholds
//   hi_exit_i         : HI-HYST (saturated), leave ABOVE when below it
//   lo_exit_i         : LO+HYST (saturated), leave BELOW when above it
//   filt_i            : required persistence count, already forced >= 1
//   gt_o, lt_o, in_o  : state ABOVE / BELOW / INSIDE
//   xup_o, xdn_o      : 1-cycle pulses on entering ABOVE / BELOW
//   clr_i, sticky_o   : sticky crossing flag and its clear (macro only)
module compmc_win_chan
   import compmc_pkg::*;
#(
   parameter int unsigned WIDTH      = 12,
   parameter int unsigned FILT_W     = 4,
   parameter int unsigned SIGNED_CMP = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sample_i,
   input  logic [WIDTH-1:0]  a_i,
   input  logic [WIDTH-1:0]  hi_i,
   input  logic [WIDTH-1:0]  lo_i,
   input  logic [WIDTH-1:0]  hi_exit_i,
   input  logic [WIDTH-1:0]  lo_exit_i,
   input  logic [FILT_W-1:0] filt_i,
   output logic              gt_o,
   output logic              lt_o,
   output logic              in_o,
   output logic              xup_o,
   output logic              xdn_o
`ifdef STICKY_XING_EN
   ,
   input  logic              clr_i,
   output logic              sticky_o
`endif
);

   win_state_e        state_q, state_d;
   win_state_e        cand_q, cand_d;
   win_state_e        target;
   logic [FILT_W-1:0] cnt_q, cnt_d;
   logic              xup_q, xup_d;
   logic              xdn_q, xdn_d;
   logic              above, below, under_hx, over_lx;

   always_comb begin
      if (SIGNED_CMP != 0) begin
         above    = $signed(a_i) > $signed(hi_i);
         below    = $signed(a_i) < $signed(lo_i);
         under_hx = $signed(a_i) < $signed(hi_exit_i);
         over_lx  = $signed(a_i) > $signed(lo_exit_i);
      end else begin
         above    = a_i > hi_i;
         below    = a_i < lo_i;
         under_hx = a_i < hi_exit_i;
         over_lx  = a_i > lo_exit_i;
      end
   end

   // A>HI is tested first everywhere so a HI<LO misconfiguration resolves to ABOVE.
   always_comb begin
      target = state_q;
      unique case (state_q)
         ST_ABOVE: begin
            if (above)         target = ST_ABOVE;
            else if (below)    target = ST_BELOW;
            else if (under_hx) target = ST_INSIDE;
         end
         ST_BELOW: begin
            if (above)        target = ST_ABOVE;
            else if (over_lx) target = ST_INSIDE;
         end
         default: begin
            if (above)      target = ST_ABOVE;
            else if (below) target = ST_BELOW;
            else            target = ST_INSIDE;
         end
      endcase
   end

   always_comb begin
      logic [FILT_W-1:0] cnt_next;
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      xup_d    = 1'b0;
      xdn_d    = 1'b0;
      cnt_next = cnt_q;
      if (sample_i) begin
         if (target == state_q) begin
            cnt_d = '0;
         end else begin
            // A changed candidate (or an idle counter) restarts the run at 1.
            if ((cnt_q != '0) && (target == cand_q)) begin
               cnt_next = (&cnt_q) ? cnt_q : cnt_q + FILT_W'(1);
            end else begin
               cnt_next = FILT_W'(1);
            end
            cand_d = target;
            if (cnt_next >= filt_i) begin
               state_d = target;
               cnt_d   = '0;
               xup_d   = (target == ST_ABOVE);
               xdn_d   = (target == ST_BELOW);
            end else begin
               cnt_d = cnt_next;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_INSIDE;
         cand_q  <= ST_INSIDE;
         cnt_q   <= '0;
         xup_q   <= 1'b0;
         xdn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         xup_q   <= xup_d;
         xdn_q   <= xdn_d;
      end
   end

   assign gt_o  = (state_q == ST_ABOVE);
   assign lt_o  = (state_q == ST_BELOW);
   assign in_o  = (state_q == ST_INSIDE);
   assign xup_o = xup_q;
   assign xdn_o = xdn_q;

`ifdef STICKY_XING_EN
   logic sticky_q;

   // Set from the visible pulse, so a clear in the pulse cycle loses to it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sticky_q <= 1'b0;
      end else if (xup_q || xdn_q) begin
         sticky_q <= 1'b1;
      end else if (clr_i) begin
         sticky_q <= 1'b0;
      end
   end

   assign sticky_o = sticky_q;
`endif

endmodule

// File: rtl/compmc_window_filt.sv
// N-channel registered window comparator with hysteresis and persistence
// filtering. Stage 1 registers the EN-qualified sample and the saturated
// exit thresholds; stage 2 (one compmc_win_chan per channel) updates state.
// Optional feature macro: STICKY_XING_EN (adds CLR / STICKY).
//   CLK, RST          : clock, synchronous active-high reset
//   EN                : sample strobe
//   A                 : CHANNELS packed samples, channel i at A[i*WIDTH +: WIDTH]
//   HI_TH, LO_TH      : shared window thresholds
//   HYST              : hysteresis magnitude (unsigned)
//   FILT              : persistence count, 0 treated as 1
//   GT, LT, IN        : per-channel state ABOVE / BELOW / INSIDE
//   XUP, XDN          : per-channel entry pulses
//   VALID             : pulse aligned with each state update
//   CLR, STICKY       : sticky crossing flags and clear (macro only)
module compmc_window_filt
   import compmc_pkg::*;
#(
   parameter int unsigned WIDTH      = 12,
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned FILT_W     = 4,
   parameter int unsigned SIGNED_CMP = 0
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      EN,
   input  logic [CHANNELS*WIDTH-1:0] A,
   input  logic [WIDTH-1:0]          HI_TH,
   input  logic [WIDTH-1:0]          LO_TH,
   input  logic [WIDTH-1:0]          HYST,
   input  logic [FILT_W-1:0]         FILT,
   output logic [CHANNELS-1:0]       GT,
   output logic [CHANNELS-1:0]       LT,
   output logic [CHANNELS-1:0]       IN,
   output logic [CHANNELS-1:0]       XUP,
   output logic [CHANNELS-1:0]       XDN,
   output logic                      VALID
`ifdef STICKY_XING_EN
   ,
   input  logic                      CLR,
   output logic [CHANNELS-1:0]       STICKY
`endif
);

   logic [CHANNELS*WIDTH-1:0] a_q;
   logic [WIDTH-1:0]          hi_q, lo_q;
   logic [WIDTH-1:0]          hi_exit_q, hi_exit_d;
   logic [WIDTH-1:0]          lo_exit_q, lo_exit_d;
   logic [FILT_W-1:0]         filt_q;
   logic                      sample_q;
   logic                      valid_q;

   always_comb begin
      logic [SAT_W-1:0] hi_ext, lo_ext, hyst_ext;
      hyst_ext = SAT_W'(HYST);
      if (SIGNED_CMP != 0) begin
         hi_ext    = {{(SAT_W-WIDTH){HI_TH[WIDTH-1]}}, HI_TH};
         lo_ext    = {{(SAT_W-WIDTH){LO_TH[WIDTH-1]}}, LO_TH};
         hi_exit_d = WIDTH'(sat_sub_s(hi_ext, hyst_ext, WIDTH));
         lo_exit_d = WIDTH'(sat_add_s(lo_ext, hyst_ext, WIDTH));
      end else begin
         hi_ext    = SAT_W'(HI_TH);
         lo_ext    = SAT_W'(LO_TH);
         hi_exit_d = WIDTH'(sat_sub_u(hi_ext, hyst_ext));
         lo_exit_d = WIDTH'(sat_add_u(lo_ext, hyst_ext, WIDTH));
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         a_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         hi_exit_q <= '0;
         lo_exit_q <= '0;
         filt_q    <= FILT_W'(1);
         sample_q  <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         sample_q <= EN;
         valid_q  <= sample_q;
         if (EN) begin
            a_q       <= A;
            hi_q      <= HI_TH;
            lo_q      <= LO_TH;
            hi_exit_q <= hi_exit_d;
            lo_exit_q <= lo_exit_d;
            filt_q    <= (FILT == '0) ? FILT_W'(1) : FILT;
         end
      end
   end

   assign VALID = valid_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      compmc_win_chan #(
         .WIDTH      (WIDTH),
         .FILT_W     (FILT_W),
         .SIGNED_CMP (SIGNED_CMP)
      ) u_chan (
         .clk_i     (CLK),
         .rst_i     (RST),
         .sample_i  (sample_q),
         .a_i       (a_q[i*WIDTH +: WIDTH]),
         .hi_i      (hi_q),
         .lo_i      (lo_q),
         .hi_exit_i (hi_exit_q),
         .lo_exit_i (lo_exit_q),
         .filt_i    (filt_q),
         .gt_o      (GT[i]),
         .lt_o      (LT[i]),
         .in_o      (IN[i]),
         .xup_o     (XUP[i]),
         .xdn_o     (XDN[i])
`ifdef STICKY_XING_EN
         ,
         .clr_i     (CLR),
         .sticky_o  (STICKY[i])
`endif
      );
   end

endmodule

// File: tb/tb_compmc_window_filt.sv
// Drives an unsigned and a signed instance with identical stimulus and checks
// both against a behavioural window/filter model every cycle.
module tb_compmc_window_filt;

   localparam int W  = 12;
   localparam int CH = 4;
   localparam int FW = 4;

   logic            CLK, RST, EN, CLR;
   logic [CH*W-1:0] A;
   logic [W-1:0]    HI_TH, LO_TH, HYST;
   logic [FW-1:0]   FILT;

   logic [CH-1:0] gt_u, lt_u, in_u, xup_u, xdn_u;
   logic [CH-1:0] gt_s, lt_s, in_s, xup_s, xdn_s;
   logic          valid_u, valid_s;
`ifdef STICKY_XING_EN
   logic [CH-1:0] sticky_u, sticky_s;
`endif

   compmc_window_filt #(.WIDTH(W), .CHANNELS(CH), .FILT_W(FW), .SIGNED_CMP(0)) u_dut_u (
      .CLK(CLK), .RST(RST), .EN(EN), .A(A), .HI_TH(HI_TH), .LO_TH(LO_TH), .HYST(HYST),
      .FILT(FILT), .GT(gt_u), .LT(lt_u), .IN(in_u), .XUP(xup_u), .XDN(xdn_u), .VALID(valid_u)
`ifdef STICKY_XING_EN
      , .CLR(CLR), .STICKY(sticky_u)
`endif
   );

   compmc_window_filt #(.WIDTH(W), .CHANNELS(CH), .FILT_W(FW), .SIGNED_CMP(1)) u_dut_s (
      .CLK(CLK), .RST(RST), .EN(EN), .A(A), .HI_TH(HI_TH), .LO_TH(LO_TH), .HYST(HYST),
      .FILT(FILT), .GT(gt_s), .LT(lt_s), .IN(in_s), .XUP(xup_s), .XDN(xdn_s), .VALID(valid_s)
`ifdef STICKY_XING_EN
      , .CLR(CLR), .STICKY(sticky_s)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model: 0=INSIDE 1=ABOVE 2=BELOW; index [mode][channel], mode 1 = signed.
   bit          s1_v;
   logic [CH*W-1:0] s1_a;
   logic [W-1:0] s1_hi, s1_lo, s1_hy;
   int          s1_filt;
   int          m_st[2][CH], m_cand[2][CH], m_cnt[2][CH];
   bit          m_xup[2][CH], m_xdn[2][CH], m_sticky[2][CH];
   bit          m_valid[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic longint val(input int m, input logic [W-1:0] x);
      if (m != 0) return longint'($signed(x));
      return longint'({52'd0, x});
   endfunction

   task automatic chan_step(input int m, input int c);
      longint a, hi, lo, hy, mn, mx, hx, lx;
      int tgt, need;
      a  = val(m, s1_a[c*W +: W]);
      hi = val(m, s1_hi);
      lo = val(m, s1_lo);
      hy = val(0, s1_hy);
      mn = (m != 0) ? -2048 : 0;
      mx = (m != 0) ? 2047 : 4095;
      hx = hi - hy; if (hx < mn) hx = mn;
      lx = lo + hy; if (lx > mx) lx = mx;
      case (m_st[m][c])
         1:       tgt = (a > hi) ? 1 : (a < lo) ? 2 : (a < hx) ? 0 : 1;
         2:       tgt = (a > hi) ? 1 : (a > lx) ? 0 : 2;
         default: tgt = (a > hi) ? 1 : (a < lo) ? 2 : 0;
      endcase
      need = (s1_filt == 0) ? 1 : s1_filt;
      if (tgt == m_st[m][c]) begin
         m_cnt[m][c] = 0;
      end else begin
         if (m_cnt[m][c] > 0 && tgt == m_cand[m][c]) m_cnt[m][c] = (m_cnt[m][c] < 15) ? m_cnt[m][c] + 1 : 15;
         else m_cnt[m][c] = 1;
         m_cand[m][c] = tgt;
         if (m_cnt[m][c] >= need) begin
            m_st[m][c]  = tgt;
            m_cnt[m][c] = 0;
            m_xup[m][c] = (tgt == 1);
            m_xdn[m][c] = (tgt == 2);
         end
      end
   endtask

   // Advance the model by one rising edge using the inputs present at that edge.
   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < CH; c++) begin
            if (RST) begin
               m_st[m][c] = 0; m_cand[m][c] = 0; m_cnt[m][c] = 0;
               m_xup[m][c] = 0; m_xdn[m][c] = 0; m_sticky[m][c] = 0;
            end else begin
               if (m_xup[m][c] || m_xdn[m][c]) m_sticky[m][c] = 1;
               else if (CLR) m_sticky[m][c] = 0;
               m_xup[m][c] = 0;
               m_xdn[m][c] = 0;
               if (s1_v) chan_step(m, c);
            end
         end
         m_valid[m] = RST ? 1'b0 : s1_v;
      end
      if (RST) begin
         s1_v = 0;
      end else begin
         if (EN) begin
            s1_a = A; s1_hi = HI_TH; s1_lo = LO_TH; s1_hy = HYST; s1_filt = int'(FILT);
         end
         s1_v = EN;
      end
   endtask

   function automatic logic [CH-1:0] exp_of(input int m, input int k);
      logic [CH-1:0] v;
      for (int c = 0; c < CH; c++) begin
         case (k)
            0:       v[c] = (m_st[m][c] == 1);
            1:       v[c] = (m_st[m][c] == 2);
            2:       v[c] = (m_st[m][c] == 0);
            3:       v[c] = m_xup[m][c];
            4:       v[c] = m_xdn[m][c];
            default: v[c] = m_sticky[m][c];
         endcase
      end
      return v;
   endfunction

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("gt_u", gt_u, exp_of(0, 0));
         chk("lt_u", lt_u, exp_of(0, 1));
         chk("in_u", in_u, exp_of(0, 2));
         chk("xup_u", xup_u, exp_of(0, 3));
         chk("xdn_u", xdn_u, exp_of(0, 4));
         chk("valid_u", valid_u, m_valid[0]);
         chk("gt_s", gt_s, exp_of(1, 0));
         chk("lt_s", lt_s, exp_of(1, 1));
         chk("in_s", in_s, exp_of(1, 2));
         chk("xup_s", xup_s, exp_of(1, 3));
         chk("xdn_s", xdn_s, exp_of(1, 4));
         chk("valid_s", valid_s, m_valid[1]);
`ifdef STICKY_XING_EN
         chk("sticky_u", sticky_u, exp_of(0, 5));
         chk("sticky_s", sticky_s, exp_of(1, 5));
`endif
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      model_edge();
      chk_en = 1'b1;
   endtask

   task automatic send();
      EN = 1'b1;
      tick();
      EN = 1'b0;
   endtask

   task automatic put(input int ch, input int v);
      A[ch*W +: W] = W'(v);
   endtask

   task automatic rand_inputs();
      int lo, hi;
      RST = ($urandom_range(0, 299) == 0);
      EN  = ($urandom_range(0, 3) != 0);
      CLR = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) begin
         lo = int'($urandom_range(0, 2000));
         hi = lo + int'($urandom_range(0, 2000));
         if ($urandom_range(0, 7) == 0) begin
            HI_TH = W'(lo); LO_TH = W'(hi);
         end else begin
            HI_TH = W'(hi); LO_TH = W'(lo);
         end
         HYST = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 300));
      end
      if ($urandom_range(0, 39) == 0) FILT = ($urandom_range(0, 9) == 0) ? FW'($urandom) :
                                             FW'($urandom_range(0, 4));
      for (int c = 0; c < CH; c++) begin
         case ($urandom_range(0, 3))
            0: put(c, int'($urandom_range(0, 4095)));
            1: put(c, int'(HI_TH) + int'($urandom_range(0, 240)) - 120);
            2: put(c, int'(LO_TH) + int'($urandom_range(0, 240)) - 120);
            default: ;
         endcase
      end
   endtask

   initial begin
      RST = 1'b1; EN = 1'b0; CLR = 1'b0;
      A = {CH{12'd2000}};
      HI_TH = 12'd3000; LO_TH = 12'd1000; HYST = 12'd100; FILT = 4'd1;
      s1_v = 0; s1_a = '0; s1_hi = '0; s1_lo = '0; s1_hy = '0; s1_filt = 1;

      // Reset state
      tick(); tick();
      chk("rst_in", in_u, 4'hF);
      chk("rst_gt", gt_u, 4'h0);
      chk("rst_lt", lt_u, 4'h0);
      chk("rst_xup", xup_u, 4'h0);
      chk("rst_xdn", xdn_u, 4'h0);
      chk("rst_valid", valid_u, 1'b0);
      chk("rst_in_s", in_s, 4'hF);
      RST = 1'b0;

      // Reset in the middle of a filter run discards the partial count
      FILT = 4'd3; put(0, 3001);
      EN = 1'b1; tick(); tick(); EN = 1'b0;
      RST = 1'b1; tick(); RST = 1'b0;
      send(); send(); tick();
      chk("rstmid_gt0", gt_u[0], 1'b0);
      put(0, 2000); send(); tick();

      // FILT=1 entry, hold inside hysteresis band, exit below HI-HYST
      FILT = 4'd1; put(0, 3001); send(); tick();
      chk("t2_gt0", gt_u[0], 1'b1);
      chk("t2_xup0", xup_u[0], 1'b1);
      chk("t2_valid", valid_u, 1'b1);
      tick();
      chk("t2_xup0_drop", xup_u[0], 1'b0);
      chk("t2_valid_drop", valid_u, 1'b0);
      put(0, 2950); send(); tick();
      chk("t2_hold", gt_u[0], 1'b1);
      put(0, 2899); send(); tick();
      chk("t2_in0", in_u[0], 1'b1);

      // FILT=3: interrupted run, then three back-to-back qualifying samples
      FILT = 4'd3; put(0, 3001); send(); put(0, 2000); send(); tick(); tick();
      chk("t3_nochg", gt_u[0], 1'b0);
      put(0, 3001); EN = 1'b1; tick(); tick(); tick(); EN = 1'b0;
      chk("t3_early", gt_u[0], 1'b0);
      tick();
      chk("t3_gt0", gt_u[0], 1'b1);
      chk("t3_xup0", xup_u[0], 1'b1);

      // ABOVE -> BELOW directly, with EN gaps afterwards
      FILT = 4'd1; put(1, 3500); send(); tick();
      chk("t4_gt1", gt_u[1], 1'b1);
      put(1, 500); send(); tick();
      chk("t4_lt1", lt_u[1], 1'b1);
      chk("t4_xdn1", xdn_u[1], 1'b1);
      chk("t4_gt1_off", gt_u[1], 1'b0);
      tick();
      chk("t4_gap_valid", valid_u, 1'b0);
      chk("t4_gap_xdn", xdn_u[1], 1'b0);
      tick();
      chk("t4_gap_valid2", valid_u, 1'b0);

      // LO+HYST saturates at 4095, so A=4095 cannot leave BELOW
      HI_TH = 12'd4095; LO_TH = 12'd4050; HYST = 12'd100;
      put(2, 100); send(); tick();
      chk("t5_lt2", lt_u[2], 1'b1);
      put(2, 4095); send(); tick();
      chk("t5_hold", lt_u[2], 1'b1);
      chk("t5_in2", in_u[2], 1'b0);

      // Signed compare, and sticky set beating a simultaneous clear
      HI_TH = 12'd1000; LO_TH = 12'hF9C; HYST = 12'd10;
      put(0, 12'h800); send(); tick();
      chk("t6_lt_s0", lt_s[0], 1'b1);
      put(0, 2000); send(); tick();
      chk("t6_xup_s0", xup_s[0], 1'b1);
      CLR = 1'b1; tick(); CLR = 1'b0;
`ifdef STICKY_XING_EN
      chk("t6_sticky_hold", sticky_s[0], 1'b1);
`endif
      CLR = 1'b1; tick(); CLR = 1'b0;
`ifdef STICKY_XING_EN
      chk("t6_sticky_clr", sticky_s[0], 1'b0);
`endif

      // Randomized phase
      HI_TH = 12'd3000; LO_TH = 12'd1000; HYST = 12'd100; FILT = 4'd2;
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         tick();
      end
      RST = 1'b0; EN = 1'b0; CLR = 1'b0;
      tick(); tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
